// File: rtl/virtq_notify_sched_pkg.sv
// Shared types and helpers for the virtqueue notify scheduler.
// Holds the FSM state encoding, default sizing and the round-robin pick function.
package virtq_sched_pkg;

    localparam int NUM_Q_DEF = 3;
    localparam int QID_W_DEF = 2;

    // Widest request vector the pick helper handles; qids fit in 4 bits.
    localparam int MAX_Q = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] qid;
    } rr_pick_t;

    // First set request strictly after 'last', wrapping modulo num_q.
    // 'last' itself is the lowest-priority candidate.
    function automatic rr_pick_t rr_pick(input logic [MAX_Q-1:0] req,
                                         input int num_q,
                                         input int last);
        rr_pick_t r;
        int       idx;
        r   = '0;
        idx = 0;
        for (int i = 1; i <= MAX_Q; i++) begin
            if (i <= num_q && !r.found) begin
                idx = (last + i) % num_q;
                if (req[idx[3:0]]) begin
                    r.found = 1'b1;
                    r.qid   = idx[3:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/virtq_notify_sched_if.sv
// Scheduler <-> DMA service engine bundle.
// Handshake: the scheduler raises svc_req_valid with svc_req_qid and holds both
// stable until the cycle svc_req_ready is high; the transfer happens on the
// rising clock edge where valid && ready. svc_done_* is a one-cycle pulse from
// the engine with no back-pressure.
interface virtq_notify_sched_if
    import virtq_sched_pkg::*;
#(
    parameter int QID_W = QID_W_DEF
) ();

    logic             svc_req_valid;
    logic [QID_W-1:0] svc_req_qid;
    logic             svc_req_ready;
    logic             svc_done_valid;
    logic [QID_W-1:0] svc_done_qid;
    logic             svc_done_more;
    logic             svc_done_used;

    // Scheduler side.
    modport master (
        output svc_req_valid,
        output svc_req_qid,
        input  svc_req_ready,
        input  svc_done_valid,
        input  svc_done_qid,
        input  svc_done_more,
        input  svc_done_used
    );

    // DMA engine side.
    modport slave (
        input  svc_req_valid,
        input  svc_req_qid,
        output svc_req_ready,
        output svc_done_valid,
        output svc_done_qid,
        output svc_done_more,
        output svc_done_used
    );

endinterface

// File: rtl/virtq_rr_arb.sv
// Combinational round-robin arbiter: picks the first asserted request after
// the previous grant, wrapping around NUM_Q entries.
module virtq_rr_arb
    import virtq_sched_pkg::*;
#(
    parameter int NUM_Q = NUM_Q_DEF,
    parameter int QID_W = QID_W_DEF
) (
    input  logic [NUM_Q-1:0] req,
    input  logic [QID_W-1:0] last,
    output logic             found,
    output logic [QID_W-1:0] grant
);

    rr_pick_t         pick;
    logic [MAX_Q-1:0] req_ext;

    // Widen the request vector, run the shared pick and narrow the result.
    always_comb begin
        req_ext             = '0;
        req_ext[NUM_Q-1:0]  = req;
        pick                = rr_pick(req_ext, NUM_Q, int'(last));
        found               = pick.found;
        grant               = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (pick.qid == 4'(q)) grant = QID_W'(q);
        end
    end

endmodule

// File: rtl/virtq_notify_sched.sv
// Virtqueue notify scheduler: latches doorbells as pending bits, issues one
// service request at a time round-robin to the DMA engine, and coalesces
// used-ring completions into a single level interrupt request.
module virtq_notify_sched
    import virtq_sched_pkg::*;
#(
    parameter int          NUM_Q       = NUM_Q_DEF,
    parameter int          QID_W       = QID_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 notify_valid,
    input  logic [QID_W-1:0]     notify_qid,
    input  logic [NUM_Q-1:0]     queue_ready,
    virtq_notify_sched_if.master svc,
    output logic                 irq_req,
    input  logic                 irq_ack,
    output logic [NUM_Q-1:0]     pending,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 qid_err,
    output logic [15:0]          drop_cnt,
    output state_t               dbg_state
);

    // Timer value whose increment would reach TIMEOUT_CYC.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t           state, state_nxt;
    logic [QID_W-1:0] cur_qid, cur_qid_nxt;
    logic [QID_W-1:0] rr_ptr;
    logic [15:0]      timer;
    logic             irq_pend;
    logic [NUM_Q-1:0] pending_nxt;
    logic [NUM_Q-1:0] arb_req;
    logic             arb_found;
    logic [QID_W-1:0] arb_grant;

    logic notify_legal;
    logic req_hs;
    logic done_ok;
    logic done_bad;
    logic tmo_hit;

    assign notify_legal = notify_valid && (int'(notify_qid) < NUM_Q);
    assign req_hs       = (state == ISSUE) && svc.svc_req_ready;
    assign done_ok      = (state == WAIT_DONE) && svc.svc_done_valid &&
                          (svc.svc_done_qid == cur_qid);
    assign done_bad     = svc.svc_done_valid && !done_ok;
    assign tmo_hit      = (state == WAIT_DONE) && !done_ok && (timer == TMO_LAST);
    assign arb_req      = pending & queue_ready;

    virtq_rr_arb #(
        .NUM_Q (NUM_Q),
        .QID_W (QID_W)
    ) u_arb (
        .req   (arb_req),
        .last  (rr_ptr),
        .found (arb_found),
        .grant (arb_grant)
    );

    assign svc.svc_req_valid = (state == ISSUE);
    assign svc.svc_req_qid   = cur_qid;
    assign busy              = (state != IDLE);
    assign irq_req           = irq_pend;
    assign dbg_state         = state;

    // FSM state and the queue currently being served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_qid <= '0;
        end else begin
            state   <= state_nxt;
            cur_qid <= cur_qid_nxt;
        end
    end

    // Next state: pick in IDLE, hold request in ISSUE, wait for done or timeout.
    always_comb begin
        state_nxt   = state;
        cur_qid_nxt = cur_qid;
        unique case (state)
            IDLE: begin
                if (arb_found) begin
                    cur_qid_nxt = arb_grant;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                if (req_hs) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_ok || tmo_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pending bits: clear on issue, set on notify/re-arm, disable wins over all.
    always_comb begin
        pending_nxt = pending;
        for (int q = 0; q < NUM_Q; q++) begin
            if (req_hs && cur_qid == QID_W'(q)) pending_nxt[q] = 1'b0;
            if (notify_valid && notify_qid == QID_W'(q)) pending_nxt[q] = 1'b1;
            if (done_ok && svc.svc_done_more && cur_qid == QID_W'(q)) pending_nxt[q] = 1'b1;
            if (!queue_ready[q]) pending_nxt[q] = 1'b0;
        end
    end

    // Pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

    // Round-robin pointer follows accepted grants; timer restarts per pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= QID_W'(NUM_Q - 1);
            timer  <= '0;
        end else begin
            if (req_hs) begin
                rr_ptr <= cur_qid;
                timer  <= '0;
            end else if (state == WAIT_DONE) begin
                timer  <= timer + 16'd1;
            end
        end
    end

    // Interrupt coalescing, sticky errors and the saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_pend    <= 1'b0;
            timeout_err <= 1'b0;
            qid_err     <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (done_ok && svc.svc_done_used) irq_pend <= 1'b1;
            else if (irq_ack)                 irq_pend <= 1'b0;
            if (tmo_hit) timeout_err <= 1'b1;
            if (done_bad || (notify_valid && !notify_legal)) qid_err <= 1'b1;
            if (notify_legal && !queue_ready[notify_qid] && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_virtq_notify_sched.sv
// Bench for virtq_notify_sched: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_virtq_notify_sched;
    import virtq_sched_pkg::*;

    localparam int NQ  = 3;
    localparam int QW  = 2;
    localparam int TMO = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           notify_valid;
    logic [QW-1:0]  notify_qid;
    logic [NQ-1:0]  queue_ready;
    logic           irq_req;
    logic           irq_ack;
    logic [NQ-1:0]  pending;
    logic           busy;
    logic           timeout_err;
    logic           qid_err;
    logic [15:0]    drop_cnt;
    state_t         dbg_state;

    virtq_notify_sched_if #(.QID_W(QW)) svc ();

    virtq_notify_sched #(.NUM_Q(NQ), .QID_W(QW), .TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .notify_valid (notify_valid),
        .notify_qid   (notify_qid),
        .queue_ready  (queue_ready),
        .svc          (svc),
        .irq_req      (irq_req),
        .irq_ack      (irq_ack),
        .pending      (pending),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .qid_err      (qid_err),
        .drop_cnt     (drop_cnt),
        .dbg_state    (dbg_state)
    );

    int n_total = 0;
    int n_bad   = 0;

    // ---------------- reference model ----------------
    // phase: 0 = no service, 1 = request offered, 2 = engine working
    bit  m_pend[NQ];
    int  m_phase, m_cur, m_last, m_timer, m_drop;
    bit  m_irq, m_tmo, m_qerr;
    logic [QW-1:0] exp_q[$];
    int  grant_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NQ; k++) m_pend[k] = 1'b0;
        m_phase = 0; m_cur = 0; m_last = NQ - 1; m_timer = 0; m_drop = 0;
        m_irq = 1'b0; m_tmo = 1'b0; m_qerr = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model across one clock edge using the inputs presented to it.
    task automatic model_step();
        bit hs, dok;
        bit np[NQ];
        int q;
        hs  = (m_phase == 1) && svc.svc_req_ready;
        dok = (m_phase == 2) && svc.svc_done_valid && (int'(svc.svc_done_qid) == m_cur);
        for (int k = 0; k < NQ; k++) begin
            np[k] = m_pend[k];
            if (hs && m_cur == k) np[k] = 1'b0;
            if (notify_valid && int'(notify_qid) == k && queue_ready[k]) np[k] = 1'b1;
            if (dok && m_cur == k && svc.svc_done_more && queue_ready[k]) np[k] = 1'b1;
            if (!queue_ready[k]) np[k] = 1'b0;
        end
        if (notify_valid && int'(notify_qid) >= NQ) m_qerr = 1'b1;
        if (svc.svc_done_valid && !dok) m_qerr = 1'b1;
        if (notify_valid && int'(notify_qid) < NQ && !queue_ready[notify_qid] && m_drop < 65535)
            m_drop++;
        if (irq_ack) m_irq = 1'b0;
        if (dok && svc.svc_done_used) m_irq = 1'b1;
        case (m_phase)
            0: begin
                for (int k = 1; k <= NQ; k++) begin
                    q = (m_last + k) % NQ;
                    if (m_phase == 0 && m_pend[q] && queue_ready[q]) begin
                        m_cur = q;
                        m_phase = 1;
                        exp_q.push_back(QW'(q));
                    end
                end
            end
            1: if (hs) begin m_last = m_cur; m_timer = 0; m_phase = 2; end
            default: begin
                if (dok) m_phase = 0;
                else if (m_timer == TMO - 1) begin m_phase = 0; m_tmo = 1'b1; end
                else m_timer++;
            end
        endcase
        for (int k = 0; k < NQ; k++) m_pend[k] = np[k];
    endtask

    task automatic check_outputs();
        logic [NQ-1:0] pv;
        state_t es;
        for (int k = 0; k < NQ; k++) pv[k] = m_pend[k];
        es = (m_phase == 0) ? IDLE : (m_phase == 1) ? ISSUE : WAIT_DONE;
        check("req_valid", svc.svc_req_valid, m_phase == 1);
        check("req_qid", svc.svc_req_qid, m_cur);
        check("pending", pending, pv);
        check("busy", busy, m_phase != 0);
        check("state", dbg_state, es);
        check("irq_req", irq_req, m_irq);
        check("timeout_err", timeout_err, m_tmo);
        check("qid_err", qid_err, m_qerr);
        check("drop_cnt", drop_cnt, m_drop);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge with inputs set; scoreboards grants, clocks, checks.
    task automatic cycle();
        if (svc.svc_req_valid && svc.svc_req_ready) begin
            if (exp_q.size() == 0) check("grant_unexpected", 1, 0);
            else check("grant_qid", svc.svc_req_qid, exp_q.pop_front());
            grant_log.push_back(int'(svc.svc_req_qid));
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        notify_valid = 1'b0;
        svc.svc_done_valid = 1'b0;
        irq_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_notify(input int q);
        notify_valid = 1'b1;
        notify_qid = QW'(q);
        cycle();
    endtask

    task automatic do_done(input int q, input bit more, input bit used);
        svc.svc_done_valid = 1'b1;
        svc.svc_done_qid = QW'(q);
        svc.svc_done_more = more;
        svc.svc_done_used = used;
        cycle();
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!svc.svc_req_valid && n < 40) begin cycle(); n++; end
        check(tag, svc.svc_req_valid, 1'b1);
    endtask

    // Engine behaviour: accept the offered request, optionally re-notify it, finish.
    task automatic serve_one(input bit renotify, input bit more, input bit used);
        logic [QW-1:0] q;
        wait_req("serve_req");
        q = svc.svc_req_qid;
        svc.svc_req_ready = 1'b1;
        cycle();
        svc.svc_req_ready = 1'b0;
        if (renotify) do_notify(int'(q));
        do_done(int'(q), more, used);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        notify_valid = 1'b0; notify_qid = '0; queue_ready = '1; irq_ack = 1'b0;
        svc.svc_req_ready = 1'b0; svc.svc_done_valid = 1'b0; svc.svc_done_qid = '0;
        svc.svc_done_more = 1'b0; svc.svc_done_used = 1'b0;
        model_reset();
        grant_log.delete();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1);
    end

    // ---------------- scenarios ----------------
    initial begin
        @(negedge clk);

        // Single notify: request two cycles after the pulse, then irq and ack.
        reset_dut();
        do_notify(1);
        check("t1_no_req_yet", svc.svc_req_valid, 1'b0);
        cycle();
        check("t1_req_valid", svc.svc_req_valid, 1'b1);
        check("t1_req_qid", svc.svc_req_qid, 1);
        svc.svc_req_ready = 1'b1;
        cycle();
        svc.svc_req_ready = 1'b0;
        check("t1_pending_clr", pending, 3'b000);
        do_done(1, 1'b0, 1'b1);
        check("t1_irq_set", irq_req, 1'b1);
        irq_ack = 1'b1;
        cycle();
        check("t1_irq_clr", irq_req, 1'b0);

        // Fairness: 0,1,2 then re-notified 0 comes last.
        reset_dut();
        do_notify(0); do_notify(1); do_notify(2);
        serve_one(1'b1, 1'b0, 1'b0);
        repeat (3) serve_one(1'b0, 1'b0, 1'b0);
        check("fair_len", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("fair_order", grant_log[i], (i == 3) ? 0 : i);

        // Re-arm from svc_done_more, then the same with the queue disabled.
        reset_dut();
        do_notify(2);
        serve_one(1'b0, 1'b1, 1'b0);
        check("rearm_pending", pending, 3'b100);
        wait_req("rearm_req");
        check("rearm_qid", svc.svc_req_qid, 2);
        svc.svc_req_ready = 1'b1;
        cycle();
        svc.svc_req_ready = 1'b0;
        queue_ready = 3'b011;
        do_done(2, 1'b1, 1'b0);
        idle(4);
        check("rearm_dis_pending", pending, 3'b000);
        check("rearm_dis_noreq", svc.svc_req_valid, 1'b0);
        queue_ready = 3'b111;

        // Set/clear collision on the handshake cycle.
        reset_dut();
        do_notify(1);
        cycle();
        svc.svc_req_ready = 1'b1;
        notify_valid = 1'b1; notify_qid = 2'd1;
        cycle();
        svc.svc_req_ready = 1'b0;
        check("collide_pending", pending, 3'b010);
        do_done(1, 1'b0, 1'b0);
        wait_req("collide_req");
        check("collide_qid", svc.svc_req_qid, 1);

        // Disabled queue drops, illegal qid, mismatched done.
        reset_dut();
        queue_ready = 3'b110;
        repeat (5) do_notify(0);
        idle(3);
        check("drop_cnt5", drop_cnt, 16'd5);
        check("drop_noreq", svc.svc_req_valid, 1'b0);
        queue_ready = 3'b111;
        do_notify(3);
        check("bad_notify_qid", qid_err, 1'b1);
        reset_dut();
        do_notify(1);
        wait_req("mm_req");
        svc.svc_req_ready = 1'b1;
        cycle();
        svc.svc_req_ready = 1'b0;
        do_done(0, 1'b0, 1'b0);
        check("mm_qid_err", qid_err, 1'b1);
        check("mm_stay_wait", dbg_state, WAIT_DONE);
        do_done(1, 1'b0, 1'b0);
        check("mm_back_idle", busy, 1'b0);

        // Timeout after exactly TMO cycles in WAIT_DONE.
        reset_dut();
        do_notify(0);
        wait_req("tmo_req");
        svc.svc_req_ready = 1'b1;
        cycle();
        svc.svc_req_ready = 1'b0;
        idle(TMO - 1);
        check("tmo_not_yet", timeout_err, 1'b0);
        check("tmo_still_busy", busy, 1'b1);
        cycle();
        check("tmo_err", timeout_err, 1'b1);
        check("tmo_idle", busy, 1'b0);
        check("tmo_no_rearm", pending, 3'b000);

        // Asynchronous reset while a request is offered.
        reset_dut();
        do_notify(2);
        cycle();
        check("ar_in_issue", svc.svc_req_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", svc.svc_req_valid, 1'b0);
        check("ar_qid", svc.svc_req_qid, 0);
        check("ar_pending", pending, 3'b000);
        check("ar_busy", busy, 1'b0);
        check("ar_irq", irq_req, 1'b0);
        @(negedge clk);

        // Random traffic with the bench acting as the DMA engine.
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            queue_ready = ($urandom_range(0, 7) == 0) ? NQ'($urandom_range(0, 7)) : 3'b111;
            if ($urandom_range(0, 2) == 0) begin
                notify_valid = 1'b1;
                notify_qid = ($urandom_range(0, 49) == 0) ? 2'd3 : QW'($urandom_range(0, NQ - 1));
            end
            svc.svc_req_ready = 1'($urandom_range(0, 1));
            if ((m_phase == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 49) == 0) begin
                svc.svc_done_valid = 1'b1;
                svc.svc_done_qid = ($urandom_range(0, 9) == 0) ? QW'($urandom_range(0, 3)) : QW'(m_cur);
                svc.svc_done_more = 1'($urandom_range(0, 1));
                svc.svc_done_used = 1'($urandom_range(0, 1));
            end
            irq_ack = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
